mix_columns_seq: RTL
====================

Name: mix_columns_seq

Overview:
- Iterative AES-128 MixColumns stage that sits directly downstream of ShiftRows/SubBytes and consumes GF(2^8) xtime (multiply-by-2) results.
- Accepts one 128-bit state over a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock.
- Returns the mixed state over a second valid/ready handshake.
- A per-transfer bypass flag serves the final AES round, which has no MixColumns.

Parameters:
- COLS_PER_CYCLE, 1, columns processed per clock. Legal values are 1, 2 and 4. Any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input state is valid
- in_ready  output  1  block can accept a state
- in_data  input  128  state; byte s(r,c) = in_data[127-8*(4c+r) -: 8] (FIPS-197 column-major order)
- in_bypass  input  1  sampled with in_data; 1 = pass the state through unmodified (final round)
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  result, same byte order as in_data

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE; out_valid=0, out_data=0; column counter=0; bypass register=0.
  - in_ready=0 while rst=1.
  - Reset in any state aborts the transfer in flight and discards it. No partial result is ever presented.
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, capture in_data and in_bypass, clear the column counter and go to BUSY.
  - BUSY: in_ready=0. Each cycle, overwrite columns counter..counter+COLS_PER_CYCLE-1 in place with their mixed values. If bypass=1, leave the data unchanged. Advance the counter by COLS_PER_CYCLE.
  - BUSY exit: when the last column group is written, go to DONE and set out_valid=1 on that same edge.
  - DONE: out_valid=1, out_data stable, in_ready=0. When out_ready=1, clear out_valid and go to IDLE. out_valid never drops without out_ready.
- Latency:
  - The accept edge is cycle 0. out_valid rises at the edge that ends cycle N, where N = 4/COLS_PER_CYCLE (4, 2 or 1).
  - Bypass transfers use the same latency, so round timing is uniform.
  - The minimum accept-to-accept interval is N+2 cycles: BUSY for N cycles, DONE for at least 1 cycle, then the next accept from IDLE. There is no overlapped accept.
- Column arithmetic, per column a0..a3 (xt = xtime, ^ = XOR):
  - xt(x) = (x<<1) ^ (x[7] ? 8'h1b : 8'h00), 8-bit result. This must match the team's xtime table exactly.
  - b0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3
  - b1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3
  - b2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3
  - b3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
- Inputs held while busy: in_valid is ignored outside IDLE. The held input is accepted only after the block returns to IDLE.
- Mid-operation changes: in_data and in_bypass may change freely after the accept edge without affecting the result.
- Output stall: out_ready=0 for any number of cycles holds out_data and out_valid steady.
- Simultaneous events: rst=1 with in_valid=1 means no accept. rst=1 in DONE with out_ready=1 means the transfer is dropped and out_valid=0.

Test Plan:
- FIPS column vectors, COLS_PER_CYCLE=1:
  - in_data = db135345_f20a225c_01010101_c6c6c6c6, bypass=0.
  - Expect out_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - Expect out_valid 4 cycles after accept.
- Second vector, COLS_PER_CYCLE = 2 and 4:
  - in_data = d4d4d4d5_2d26314c_db135345_f20a225c.
  - Expect d5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d after 2 and 1 cycles respectively.
- Bypass: in_data = 00112233_44556677_8899aabb_ccddeeff with in_bypass=1. Expect identical out_data with the same latency as a non-bypass transfer.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid. Expect out_data and out_valid stable, and in_ready=0 throughout while in_valid is held high.
  - Release out_ready. Expect the next state to be accepted 1 cycle later.
- Reset mid-BUSY: assert rst 2 cycles after accept. Expect out_valid=0 and out_data=0 next cycle, then in_ready=1 once rst drops. A new vector must produce the correct result.
- Randomized back-to-back transfers against the reference model:
  - 1000 random states with random bypass.
  - in_valid and out_ready toggled at random.
  - Every output must match the model, in order, with none lost or duplicated.

Source files
------------

// File: rtl/mix_columns_seq.sv
// Iterative AES-128 MixColumns: COLS_PER_CYCLE columns per clock, valid/ready in and out,
// with a per-transfer bypass for the final round.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // state | meaning
    // IDLE  | waiting for a state to accept
    // BUSY  | mixing one column group per cycle in place
    // DONE  | result held on out_data until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_cnt;
    logic           r_bypass;
    logic [127:0]   r_data;
    logic           w_accept;
    logic           w_last;
    logic [127:0]   w_mixed;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Only the columns in the current group are rewritten; the rest pass through.
    always_comb begin
        w_mixed = r_data;
        for (int c = 0; c < 4; c++) begin
            if (!r_bypass && (c >= int'(r_cnt)) && (c < int'(r_cnt) + COLS_PER_CYCLE)) begin
                w_mixed[127-32*c -: 32] = mix_col(r_data[127-32*c -: 32]);
            end
        end
    end

    assign w_last = (r_cnt == 2'(4 - COLS_PER_CYCLE));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_cnt    <= '0;
            r_bypass <= 1'b0;
        end else if (w_accept) begin
            r_data   <= in_data;
            r_bypass <= in_bypass;
            r_cnt    <= '0;
        end else if (r_state == BUSY) begin
            r_data   <= w_mixed;
            r_cnt    <= r_cnt + 2'(COLS_PER_CYCLE);
        end
    end

    // rst gates in_ready so a request presented during reset is never taken.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign out_data  = r_data;

endmodule
